// File: rtl/fir_stream_capture_if.sv
// Stream-in / read-out bundle for fir_stream_capture: FIR sample strobe plus show-ahead read port.
// Latency: pure wiring, no state.
// Backpressure: rd_ready throttles the read side only; the FIR side has no ready.
interface fir_stream_capture_if #(
   parameter int DATA_WL = 16
);
   logic                      in_valid;
   logic signed [DATA_WL-1:0] data_in;
   logic                      rd_ready;
   logic                      rd_valid;
   logic signed [DATA_WL-1:0] rd_data;

   // Producer/consumer side (FIR output plus downstream reader)
   modport master (
      output in_valid, data_in, rd_ready,
      input  rd_valid, rd_data
   );

   // Capture block side
   modport slave (
      input  in_valid, data_in, rd_ready,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/fir_stream_capture.sv
// Captures FIR output bursts into a show-ahead FIFO and reports count/overflow/burst_done per burst.
// Latency: sample written at edge N is on rd_valid/rd_data after edge N+1; burst_done is a registered pulse.
// Backpressure: none toward the FIR (full FIFO drops and sets overflow); read side is valid/ready.
// Build option: define FIR_CAPTURE_PEAK_EN to add the peak_abs output and its tracker.
module fir_stream_capture #(
   parameter int DATA_WL = 16,
   parameter int DEPTH   = 64,
   parameter int CNT_WL  = 16
) (
   input  logic                clk,
   input  logic                rst,
   fir_stream_capture_if.slave bus,
   output logic [CNT_WL-1:0]   sample_count,
   output logic                overflow,
   output logic                burst_done,
   output logic                busy
`ifdef FIR_CAPTURE_PEAK_EN
  ,output logic [DATA_WL-1:0]  peak_abs
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [CNT_WL-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_WL-1:0]  rd_data_q, rd_data_d;
   logic [CNT_WL-1:0]   cnt_q, cnt_d;
   logic                ovf_q, ovf_d;
   logic                done_q, done_d;
   logic [DATA_WL-1:0]  mem_q [DEPTH];

   logic full;
   logic rd_en;
   logic wr_en;
   logic drop;
   logic burst_start;

   // FIFO pointer arithmetic and the registered show-ahead head view
   always_comb begin
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      rd_en = rd_valid_q & bus.rd_ready;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts
      wr_en = bus.in_valid & (~full | rd_en);
      drop  = bus.in_valid & ~wr_en;
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(rd_en);
      // Compare against the pre-write pointer: a sample written this edge shows one cycle later
      rd_valid_d = (wr_ptr_q != rd_ptr_d);
      rd_data_d  = rd_valid_d ? mem_q[rd_ptr_d[AW-1:0]] : rd_data_q;
   end

   // Burst FSM: IDLE -> CAPTURE on a sample, CAPTURE -> DRAIN on a gap, DRAIN -> IDLE once empty
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) state_d = CAPTURE;
         end
         CAPTURE: begin
            if (!bus.in_valid) state_d = DRAIN;
         end
         DRAIN: begin
            if (bus.in_valid) begin
               state_d = CAPTURE;
            end else if (wr_ptr_d == rd_ptr_d) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Per-burst sample count (saturating) and sticky overflow; a resume from DRAIN keeps both
   always_comb begin
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      burst_start = (state_q == IDLE) & bus.in_valid;
      if (burst_start) begin
         cnt_d = CNT_WL'(1);
         ovf_d = drop;
      end else if (bus.in_valid) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WL'(1);
         ovf_d = ovf_q | drop;
      end
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         done_q     <= done_d;
      end
   end

   // Storage array, left unreset so it can map onto RAM
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.data_in;
   end

`ifdef FIR_CAPTURE_PEAK_EN
   localparam logic [DATA_WL-1:0] MOST_NEG = {1'b1, {(DATA_WL-1){1'b0}}};
   localparam logic [DATA_WL-1:0] MOST_POS = {1'b0, {(DATA_WL-1){1'b1}}};

   logic [DATA_WL-1:0] peak_q, peak_d;
   logic [DATA_WL-1:0] din_u;
   logic [DATA_WL-1:0] din_abs;

   // Magnitude of the incoming sample (most-negative clamps) folded into the burst maximum
   always_comb begin
      din_u   = bus.data_in;
      din_abs = din_u;
      if (din_u[DATA_WL-1]) begin
         din_abs = (din_u == MOST_NEG) ? MOST_POS : (~din_u + DATA_WL'(1));
      end
      peak_d = peak_q;
      if (burst_start) begin
         peak_d = din_abs;
      end else if (bus.in_valid && (din_abs > peak_q)) begin
         peak_d = din_abs;
      end
   end

   // Peak register, cleared with the sample counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) peak_q <= '0;
      else      peak_q <= peak_d;
   end

   assign peak_abs = peak_q;
`endif

   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign sample_count = cnt_q;
   assign overflow     = ovf_q;
   assign burst_done   = done_q;
   assign busy         = (state_q != IDLE);

endmodule
